// File: rtl/nco_table_sequencer.sv
// Two-RAM sine NCO controller: streams the table into RAM0/RAM1,
// then steps a phase accumulator and returns the selected RAM word.
module nco_table_sequencer #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [DATA_W-1:0]  src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic               csb00,
  output logic               csb01,
  output logic               web00,
  output logic               web01,
  output logic [7:0]         addr00,
  output logic [7:0]         addr01,
  output logic [DATA_W-1:0]  din00,
  output logic [DATA_W-1:0]  din01,
  input  logic [DATA_W-1:0]  dout00,
  input  logic [DATA_W-1:0]  dout01,
  output logic [DATA_W-1:0]  sine_out,
  output logic               sine_vld,
  output logic               loaded,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD0,
    LOAD1,
    RUN
  } state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic [PHASE_W-1:0] phase;
  logic [8:0]         idx;
  logic               accept;
  logic               iss_vld;
  logic               iss_sel;
  logic [RD_LAT-1:0]  pv;
  logic [RD_LAT-1:0]  ps;

  assign idx    = phase[PHASE_W-1 -: 9];
  assign accept = src_valid && src_ready;
  assign busy   = (state != IDLE);

  // Sequencer FSM with registered RAM-side strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= '0;
      loaded    <= 1'b0;
      src_ready <= 1'b0;
      csb00     <= 1'b1;
      csb01     <= 1'b1;
      web00     <= 1'b1;
      web01     <= 1'b1;
      addr00    <= '0;
      addr01    <= '0;
      din00     <= '0;
      din01     <= '0;
      iss_vld   <= 1'b0;
      iss_sel   <= 1'b0;
    end else begin
      csb00   <= 1'b1;
      csb01   <= 1'b1;
      web00   <= 1'b1;
      web01   <= 1'b1;
      iss_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD0;
            cnt       <= '0;
            loaded    <= 1'b0;
            src_ready <= 1'b1;
          end
        end
        LOAD0: begin
          if (accept) begin
            csb00  <= 1'b0;
            web00  <= 1'b0;
            addr00 <= cnt;
            din00  <= src_data;
            cnt    <= cnt + 8'd1;
            if (cnt == 8'hff) begin
              state <= LOAD1;
            end
          end
        end
        LOAD1: begin
          if (accept) begin
            csb01  <= 1'b0;
            web01  <= 1'b0;
            addr01 <= cnt;
            din01  <= src_data;
            cnt    <= cnt + 8'd1;
            if (cnt == 8'hff) begin
              state     <= RUN;
              loaded    <= 1'b1;
              phase     <= '0;
              src_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (start) begin
            state     <= LOAD0;
            cnt       <= '0;
            loaded    <= 1'b0;
            src_ready <= 1'b1;
          end else if (stop) begin
            state <= IDLE;
          end else begin
            iss_vld <= 1'b1;
            iss_sel <= idx[8];
            if (idx[8]) begin
              csb01  <= 1'b0;
              addr01 <= idx[7:0];
            end else begin
              csb00  <= 1'b0;
              addr00 <= idx[7:0];
            end
            phase <= phase + freq_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return pipeline: track select bit until dout is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv       <= '0;
      ps       <= '0;
      sine_vld <= 1'b0;
      sine_out <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
      pv[0]    <= iss_vld;
      ps[0]    <= iss_sel;
      sine_vld <= pv[RD_LAT-1];
      if (pv[RD_LAT-1]) begin
        sine_out <= ps[RD_LAT-1] ? dout01 : dout00;
      end
    end
  end

endmodule
